// File: rtl/mlp_mac_unit.sv
// ============================================================================
//  Module   : mlp_mac_unit
//  Function : signed MAC over a group of terms, then round/shift/ReLU/int8
//             saturation of the group sum for X-buffer write-back.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_mac_unit #(
  parameter int DataWidth = 8,
  parameter int AccWidth  = 24,
  parameter int Terms     = 16,
  parameter int Shift     = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        mac_valid_i,
  input  logic                        mac_last_i,
  input  logic                        relu_en_i,
  input  logic signed [DataWidth-1:0] w_rdata_i,
  input  logic signed [DataWidth-1:0] x_rdata_i,
  output logic                        out_valid_o,
  output logic signed [DataWidth-1:0] out_data_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int                  c_cnt_w    = (Terms > 1) ? $clog2(Terms) : 1;
  localparam int                  c_prod_w   = 2 * DataWidth;
  localparam logic [c_cnt_w-1:0]  c_last_cnt = c_cnt_w'(Terms - 1);
  localparam logic signed [AccWidth:0] c_max =
    {{(AccWidth + 2 - DataWidth){1'b0}}, {(DataWidth - 1){1'b1}}};
  localparam logic signed [AccWidth:0] c_min =
    {{(AccWidth + 2 - DataWidth){1'b1}}, {(DataWidth - 1){1'b0}}};

  logic                        r_s0_valid, r_s0_last, r_s0_relu;
  logic                        r_s1_valid, r_s1_last, r_s1_relu;
  logic signed [c_prod_w-1:0]  r_s1_prod;
  logic                        r_s2_valid, r_s2_relu;
  logic signed [AccWidth-1:0]  r_acc;
  logic [c_cnt_w-1:0]          r_cnt;
  logic                        r_err;
  logic                        r_out_valid;
  logic signed [DataWidth-1:0] r_out_data;

  logic signed [AccWidth:0]    w_round;
  logic signed [AccWidth:0]    w_sum;
  logic signed [AccWidth:0]    w_shr;
  logic signed [DataWidth-1:0] w_q;

  generate
    if (Shift > 0) begin : g_round
      assign w_round = (AccWidth + 1)'(1) << (Shift - 1);
    end else begin : g_no_round
      assign w_round = '0;
    end
  endgenerate

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  assign w_sum = {r_acc[AccWidth-1], r_acc} + w_round;
  assign w_shr = w_sum >>> Shift;

  always_comb begin
    w_q = w_shr[DataWidth-1:0];
    if (r_s2_relu && w_shr[AccWidth]) begin
      w_q = '0;
    end else if (w_shr > c_max) begin
      w_q = {1'b0, {(DataWidth - 1){1'b1}}};
    end else if (w_shr < c_min) begin
      w_q = {1'b1, {(DataWidth - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s0_valid  <= 1'b0;
      r_s0_last   <= 1'b0;
      r_s0_relu   <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_relu   <= 1'b0;
      r_s1_prod   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_relu   <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // S0: flags wait one cycle for the memory read data
      r_s0_valid <= mac_valid_i;
      r_s0_last  <= mac_valid_i & mac_last_i;
      r_s0_relu  <= mac_valid_i & mac_last_i & relu_en_i;

      // S1: full-precision product
      r_s1_valid <= r_s0_valid;
      r_s1_last  <= r_s0_last;
      r_s1_relu  <= r_s0_relu;
      r_s1_prod  <= c_prod_w'(w_rdata_i) * c_prod_w'(x_rdata_i);

      // S2: accumulate; a zero count starts a fresh sum
      r_s2_valid <= r_s1_valid & r_s1_last;
      r_s2_relu  <= r_s1_relu;
      if (r_s1_valid) begin
        if (r_cnt == '0) begin
          r_acc <= AccWidth'(r_s1_prod);
        end else begin
          r_acc <= r_acc + AccWidth'(r_s1_prod);
        end
        if (r_s1_last) begin
          r_cnt <= '0;
          if (r_cnt != c_last_cnt) begin
            r_err <= 1'b1;
          end
        end else if (r_cnt == c_last_cnt) begin
          r_cnt <= '0;
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end

      // S3: requantised result
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data <= w_q;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign err_o       = r_err;
  assign busy_o      = r_s0_valid | r_s1_valid | r_s2_valid | r_out_valid |
                       (r_cnt != '0);

endmodule

`default_nettype wire
